usb_data_buffer: RTL and testbench
==================================

# usb_data_buffer

Shared 64-byte first-word-fall-through byte FIFO between the host-side register interface, the USB receiver and the USB transmitter. Host or receiver bytes are pushed in. The transmitter pops bytes at packet-byte boundaries, and the host can also read bytes back. Occupancy is reported so the transmitter can decide between DATA, CRC and error-EOP.

## Interface
Parameters:
- DEPTH, 64, number of byte entries; power of two.
- OCC_W, 7, occupancy width; equals $clog2(DEPTH)+1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- n_rst  in  1  one clock; reset is synchronous and active-high (name kept for codebase consistency; asserted = 1).
- flush  in  1  clear buffer contents; wins over everything else except reset.
- store_tx_data  in  1  host pushes tx_data this cycle.
- tx_data  in  8  host byte to push.
- store_rx_packet_data  in  1  receiver pushes rx_packet_data this cycle.
- rx_packet_data  in  8  received byte to push.
- get_tx_packet_data  in  1  transmitter pops the head byte this cycle.
- tx_packet_data  out  8  combinational head byte; 8'h00 when empty.
- get_rx_data  in  1  host pops the head byte into rx_data.
- rx_data  out  8  registered host read byte.
- buffer_occupancy  out  OCC_W  stored byte count, 0..DEPTH.
- buffer_error  out  1  one-cycle pulse on an overflow, underflow or dual-source conflict.

## Operation
- Storage is a circular array with 6-bit write pointer wptr, 6-bit read pointer rptr and a 7-bit count occ. Pointers wrap 63→0 naturally; occ never wraps.
- Push request: push = store_tx_data | store_rx_packet_data.
  - Data written: tx_data if store_tx_data, else rx_packet_data.
  - Both stores asserted: tx_data is written, rx byte is dropped, buffer_error pulses.
- Pop request: pop = get_tx_packet_data | get_rx_data.
  - Both gets asserted: exactly one entry is popped; rx_data still captures the head; buffer_error pulses.
- A push is accepted if occ<DEPTH, or if occ==DEPTH and an accepted pop occurs the same cycle. Otherwise the byte is dropped and buffer_error pulses.
- A pop is accepted if occ>0. Otherwise it is ignored: rx_data holds, and buffer_error pulses.
- There is no bypass from push to pop. With occ==0 and push+pop together, the push is accepted, the pop is an underflow, and occ becomes 1.
- Accepted push+pop together leave occ unchanged; both pointers advance.
- get_rx_data accepted: rx_data <= mem[rptr].
- flush: wptr, rptr and occ go to 0. Pushes and pops in the same cycle are discarded with no error. rx_data holds.
- tx_packet_data = mem[rptr] when occ>0, else 8'h00.

## Timing
- Reset (n_rst=1 at an edge): occ=0, pointers=0, rx_data=8'h00, buffer_error=0, tx_packet_data=8'h00. Memory contents are don't-care.
- A pushed byte is visible on tx_packet_data, and occ increments, the cycle after the store edge.
- An accepted pop presents the next head on tx_packet_data, and occ decrements, the cycle after the get edge. The transmitter samples tx_packet_data in the same cycle it asserts get_tx_packet_data.
- rx_data is valid from the cycle after get_rx_data.
- buffer_error is registered. It is high for exactly one cycle following the offending edge; consecutive violations give consecutive pulses.
- Reset mid-operation discards all contents in one cycle; there is no partial state.

## Structure
- Package usb_pkg holds:
  - BUF_DEPTH=64 and BUF_OCC_W=7.
  - PID byte constants shared with usb_tx.
- Sub-module usb_buffer_mem: DEPTH×8 array with a synchronous write port and an asynchronous read port at rptr.
- Pointer, occupancy and error logic live in usb_data_buffer.

## Test plan
- Reset, then push 8'hA5, 8'h3C via store_tx_data → next cycle occ=1 with tx_packet_data=8'hA5. Then occ=2. Pop once → tx_packet_data=8'h3C, occ=1.
- Push 64 bytes 0..63, then push 8'hFF → occ stays 64, buffer_error pulses once, head=8'h00. Push+pop at occ=64 → occ=64, head=8'h01.
- Pop at occ=0 → buffer_error pulse, occ=0, tx_packet_data=8'h00. Push+pop at occ=0 → occ=1, error pulse.
- store_tx_data=1 with 8'h11 and store_rx_packet_data=1 with 8'h22 together → occ=1, head=8'h11, buffer_error pulse.
- Fill 10 bytes, advance pointers past 63 by 70 push/pop pairs, pop all → byte order preserved across the wrap. get_rx_data → rx_data equals the popped head.
- Occ=20, assert flush together with a store → occ=0 next cycle, no error, tx_packet_data=8'h00.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB constants: data buffer geometry and PID byte encodings
// used by both the buffer and the transmitter.
package usb_pkg;

    localparam int BUF_DEPTH = 64;
    localparam int BUF_OCC_W = 7;

    // Upper nibble is the one's complement of the lower nibble.
    typedef enum logic [7:0] {
        PID_OUT   = 8'hE1,
        PID_IN    = 8'h69,
        PID_SOF   = 8'hA5,
        PID_SETUP = 8'h2D,
        PID_DATA0 = 8'hC3,
        PID_DATA1 = 8'h4B,
        PID_ACK   = 8'hD2,
        PID_NAK   = 8'h5A,
        PID_STALL = 8'h1E
    } pid_e;

    localparam logic [7:0] EMPTY_BYTE = 8'h00;

    function automatic logic dual_req(input logic a, input logic b);
        return a & b;
    endfunction

endpackage

// File: rtl/usb_buffer_mem.sv
// Byte storage for the USB data buffer: one synchronous write port
// and one asynchronous read port.
module usb_buffer_mem #(
    parameter int DEPTH = 64,
    parameter int PTR_W = 6
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [7:0]       rdata
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/usb_data_buffer.sv
// Shared first-word-fall-through byte FIFO between host, USB receiver
// and USB transmitter, with occupancy and one-cycle error pulses.
module usb_data_buffer
    import usb_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH,
    parameter int OCC_W = BUF_OCC_W
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             flush,
    input  logic             store_tx_data,
    input  logic [7:0]       tx_data,
    input  logic             store_rx_packet_data,
    input  logic [7:0]       rx_packet_data,
    input  logic             get_tx_packet_data,
    output logic [7:0]       tx_packet_data,
    input  logic             get_rx_data,
    output logic [7:0]       rx_data,
    output logic [OCC_W-1:0] buffer_occupancy,
    output logic             buffer_error
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             err_q, err_d;

    logic       push, pop;
    logic       push_ok, pop_ok;
    logic       wr_en;
    logic [7:0] wdata;
    logic [7:0] head;

    usb_buffer_mem #(
        .DEPTH(DEPTH),
        .PTR_W(PTR_W)
    ) u_mem (
        .clk  (clk),
        .wr_en(wr_en),
        .waddr(wptr_q),
        .wdata(wdata),
        .raddr(rptr_q),
        .rdata(head)
    );

    always_comb begin
        push    = store_tx_data | store_rx_packet_data;
        pop     = get_tx_packet_data | get_rx_data;
        wdata   = store_tx_data ? tx_data : rx_packet_data;
        pop_ok  = pop && (occ_q != '0);
        // A full buffer can still take a byte if a slot frees this cycle.
        push_ok = push && ((occ_q != FULL) || pop_ok);
        wr_en   = push_ok && !flush && !n_rst;

        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        occ_d     = occ_q;
        rx_data_d = rx_data_q;
        err_d     = 1'b0;

        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            occ_d  = '0;
        end else begin
            wptr_d = wptr_q + PTR_W'(push_ok);
            rptr_d = rptr_q + PTR_W'(pop_ok);
            occ_d  = occ_q + OCC_W'(push_ok) - OCC_W'(pop_ok);
            if (pop_ok && get_rx_data) begin
                rx_data_d = head;
            end
            err_d = (push && !push_ok)
                  | (pop && !pop_ok)
                  | dual_req(store_tx_data, store_rx_packet_data)
                  | dual_req(get_tx_packet_data, get_rx_data);
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            occ_q     <= '0;
            rx_data_q <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            occ_q     <= occ_d;
            rx_data_q <= rx_data_d;
            err_q     <= err_d;
        end
    end

    assign tx_packet_data   = (occ_q != '0) ? head : EMPTY_BYTE;
    assign rx_data          = rx_data_q;
    assign buffer_occupancy = occ_q;
    assign buffer_error     = err_q;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Directed self-checking bench for usb_data_buffer.
module tb_usb_data_buffer;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       flush = 1'b0;
    logic       store_tx_data = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       store_rx_packet_data = 1'b0;
    logic [7:0] rx_packet_data = 8'h00;
    logic       get_tx_packet_data = 1'b0;
    logic [7:0] tx_packet_data;
    logic       get_rx_data = 1'b0;
    logic [7:0] rx_data;
    logic [6:0] buffer_occupancy;
    logic       buffer_error;

    int checks = 0;
    int errors = 0;

    usb_data_buffer dut (
        .clk                 (clk),
        .n_rst               (n_rst),
        .flush               (flush),
        .store_tx_data       (store_tx_data),
        .tx_data             (tx_data),
        .store_rx_packet_data(store_rx_packet_data),
        .rx_packet_data      (rx_packet_data),
        .get_tx_packet_data  (get_tx_packet_data),
        .tx_packet_data      (tx_packet_data),
        .get_rx_data         (get_rx_data),
        .rx_data             (rx_data),
        .buffer_occupancy    (buffer_occupancy),
        .buffer_error        (buffer_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0;
        store_tx_data = 1'b0;
        store_rx_packet_data = 1'b0;
        get_tx_packet_data = 1'b0;
        get_rx_data = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        store_tx_data = 1'b1;
        tx_data = b;
        step();
        idle();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        idle();
    endtask

    initial begin
        logic [7:0] exp_b;

        step();
        n_rst = 1'b0;
        check("rst_occ", 32'(buffer_occupancy), 0);
        check("rst_head", 32'(tx_packet_data), 8'h00);
        check("rst_rx", 32'(rx_data), 8'h00);
        check("rst_err", 32'(buffer_error), 0);

        push(8'hA5);
        check("p1_occ", 32'(buffer_occupancy), 1);
        check("p1_head", 32'(tx_packet_data), 8'hA5);
        push(8'h3C);
        check("p2_occ", 32'(buffer_occupancy), 2);
        check("p2_head", 32'(tx_packet_data), 8'hA5);
        get_tx_packet_data = 1'b1;
        step();
        idle();
        check("pop_head", 32'(tx_packet_data), 8'h3C);
        check("pop_occ", 32'(buffer_occupancy), 1);
        check("pop_err", 32'(buffer_error), 0);
        do_flush();

        for (int i = 0; i < 64; i++) push(8'(i));
        check("full_occ", 32'(buffer_occupancy), 64);
        check("full_err0", 32'(buffer_error), 0);
        push(8'hFF);
        check("ovf_occ", 32'(buffer_occupancy), 64);
        check("ovf_err", 32'(buffer_error), 1);
        check("ovf_head", 32'(tx_packet_data), 8'h00);
        step();
        check("ovf_err_once", 32'(buffer_error), 0);
        store_tx_data = 1'b1;
        tx_data = 8'h40;
        get_tx_packet_data = 1'b1;
        step();
        idle();
        check("fpp_occ", 32'(buffer_occupancy), 64);
        check("fpp_head", 32'(tx_packet_data), 8'h01);
        check("fpp_err", 32'(buffer_error), 0);

        flush = 1'b1;
        store_tx_data = 1'b1;
        tx_data = 8'h99;
        step();
        idle();
        check("fl_occ", 32'(buffer_occupancy), 0);
        check("fl_err", 32'(buffer_error), 0);
        check("fl_head", 32'(tx_packet_data), 8'h00);

        get_tx_packet_data = 1'b1;
        step();
        idle();
        check("udf_err", 32'(buffer_error), 1);
        check("udf_occ", 32'(buffer_occupancy), 0);
        check("udf_head", 32'(tx_packet_data), 8'h00);
        store_tx_data = 1'b1;
        tx_data = 8'h77;
        get_tx_packet_data = 1'b1;
        step();
        idle();
        check("epp_occ", 32'(buffer_occupancy), 1);
        check("epp_err", 32'(buffer_error), 1);
        check("epp_head", 32'(tx_packet_data), 8'h77);
        do_flush();

        store_tx_data = 1'b1;
        tx_data = 8'h11;
        store_rx_packet_data = 1'b1;
        rx_packet_data = 8'h22;
        step();
        idle();
        check("dual_occ", 32'(buffer_occupancy), 1);
        check("dual_head", 32'(tx_packet_data), 8'h11);
        check("dual_err", 32'(buffer_error), 1);
        do_flush();

        store_rx_packet_data = 1'b1;
        rx_packet_data = 8'h5E;
        step();
        idle();
        check("rxp_head", 32'(tx_packet_data), 8'h5E);
        check("rxp_err", 32'(buffer_error), 0);
        do_flush();

        for (int i = 0; i < 10; i++) push(8'h80 + 8'(i));
        for (int j = 0; j < 70; j++) begin
            exp_b = 8'h80 + 8'(j);
            check("wrap_head", 32'(tx_packet_data), 32'(exp_b));
            store_tx_data = 1'b1;
            tx_data = 8'h8A + 8'(j);
            get_tx_packet_data = 1'b1;
            step();
            idle();
            check("wrap_occ", 32'(buffer_occupancy), 10);
        end
        for (int i = 0; i < 10; i++) begin
            exp_b = 8'hC6 + 8'(i);
            check("drain_head", 32'(tx_packet_data), 32'(exp_b));
            get_rx_data = 1'b1;
            get_tx_packet_data = (i == 9);
            step();
            idle();
            check("drain_rx", 32'(rx_data), 32'(exp_b));
            check("drain_occ", 32'(buffer_occupancy), 32'(9 - i));
            check("drain_err", 32'(buffer_error), 32'(i == 9));
        end
        get_rx_data = 1'b1;
        step();
        idle();
        check("rx_hold", 32'(rx_data), 8'hCF);
        check("rx_udf_err", 32'(buffer_error), 1);

        for (int i = 0; i < 20; i++) push(8'(i + 1));
        check("o20_occ", 32'(buffer_occupancy), 20);
        flush = 1'b1;
        store_tx_data = 1'b1;
        tx_data = 8'hEE;
        get_rx_data = 1'b1;
        step();
        idle();
        check("fl20_occ", 32'(buffer_occupancy), 0);
        check("fl20_err", 32'(buffer_error), 0);
        check("fl20_head", 32'(tx_packet_data), 8'h00);
        check("fl20_rx", 32'(rx_data), 8'hCF);

        push(8'h42);
        push(8'h43);
        n_rst = 1'b1;
        step();
        n_rst = 1'b0;
        check("mrst_occ", 32'(buffer_occupancy), 0);
        check("mrst_head", 32'(tx_packet_data), 8'h00);
        check("mrst_rx", 32'(rx_data), 8'h00);
        push(8'h55);
        check("post_rst_head", 32'(tx_packet_data), 8'h55);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
